frame_buf_ctrl: RTL
===================

FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

Interface
REQ-001 Parameter BRAM_DEPTH, default 307200: pixels per frame, which is also the depth of each of the two frame-buffer banks.
REQ-002 Parameter AW, default 19: address width; SHALL satisfy 2^AW >= BRAM_DEPTH.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  sole clock; both BRAM ports and the output FIFO write side run on it.
REQ-005 i_rst  in  1  asynchronous active-high reset.
REQ-006 i_valid  in  1  input pixel strobe, one pixel per cycle when high.
REQ-007 i_sof  in  1  start of frame; meaningful only when i_valid=1, and marks the first pixel of a frame.
REQ-008 o_wr_en  out  1  BRAM port-A write enable.
REQ-009 o_wr_addr  out  AW  BRAM port-A pixel address.
REQ-010 o_wr_bank  out  1  bank selected for the port-A write.
REQ-011 i_req  in  1  display-active request.
REQ-012 i_almostfull  in  1  output FIFO almost-full flag.
REQ-013 o_rd_addr  out  AW  BRAM port-B read address.
REQ-014 o_rd_bank  out  1  bank selected for the port-B read.
REQ-015 o_fifo_wr  out  1  FIFO write enable, aligned with the BRAM read data.
REQ-016 o_frame_drop  out  1  one-cycle pulse when a completed, unread frame is overwritten.
REQ-017 o_rd_active  out  1  high while the reader FSM is in STREAM.

Function
REQ-018 Write path: o_wr_en, o_wr_addr and o_wr_bank SHALL be registered, giving one cycle of latency from i_valid to o_wr_en.
REQ-019 Write addressing: i_valid&i_sof writes address 0; each subsequent i_valid increments the address by one.
REQ-020 Write completion: the pixel written at address BRAM_DEPTH-1 completes the frame; the block SHALL set pending=1 and enter WR_DONE.
REQ-021 Write FSM states and transitions:
  - WR_IDLE -> WR_FILL on i_valid&i_sof.
  - WR_FILL -> WR_DONE on frame completion.
  - WR_DONE -> WR_FILL on i_valid&i_sof.
REQ-022 Writes outside WR_FILL SHALL be dropped (o_wr_en=0), except the sof pixel itself.
REQ-023 An i_sof in WR_FILL SHALL restart at address 0 in the same bank, with no drop pulse.
REQ-024 Banks: wr_bank and rd_bank SHALL always be complementary, except before the first swap (both reset values stated under Reset).
REQ-025 Swap condition: pending=1, or a frame completion occurring in the current cycle.
REQ-026 Swap occurrence: a swap happens either in RD_IDLE, or on the cycle the reader issues address BRAM_DEPTH-1.
REQ-027 Swap action: rd_bank <= the just-completed bank, wr_bank <= its complement, pending <= 0.
REQ-028 Reader FSM states and transitions:
  - RD_IDLE -> STREAM on the first swap.
  - STREAM is held thereafter.
  - Returns to RD_IDLE only on reset.
REQ-029 Read issue: in STREAM, a read is issued on every cycle with i_req=1 and i_almostfull=0.
REQ-030 Read address sequencing: o_rd_addr advances by one per issued read and wraps from BRAM_DEPTH-1 to 0.
REQ-031 Read hold: o_rd_addr SHALL hold its value on any cycle with no read issue.
REQ-032 Frame repeat: with no pending frame at read wrap, the same rd_bank SHALL be re-read.
REQ-033 o_fifo_wr SHALL equal the read-issue condition delayed by exactly one cycle, matching the BRAM read latency.
REQ-034 o_rd_bank SHALL change only together with a wrap of o_rd_addr to 0.
REQ-035 Drop rule: i_valid&i_sof while pending=1, in a cycle with no swap, SHALL pulse o_frame_drop, clear pending, and overwrite wr_bank starting at address 0.
REQ-036 Simultaneous sof and swap: the sof pixel SHALL be written to the post-swap wr_bank, with no drop.
REQ-037 Simultaneous completion and read wrap: the swap SHALL occur in that same cycle.
REQ-038 Backpressure: i_almostfull or a deasserted i_req SHALL stall the reader only; the write path never stalls.

Reset
REQ-039 Reset SHALL set:
  - all outputs to 0;
  - wr_bank=0, rd_bank=1, pending=0;
  - write FSM to WR_IDLE and reader FSM to RD_IDLE;
  - both address counters to 0.
REQ-040 Reset asserted mid-frame SHALL abort both paths immediately, with no o_fifo_wr issued after reset.

Verification (BRAM_DEPTH=8)
REQ-041 First frame, 8 pixels with sof on the first -> o_wr_addr 0..7 on bank 0; after the swap, rd_bank=0 and o_rd_active=1.
REQ-042 i_req=1 and i_almostfull=0 for 16 cycles in STREAM -> o_rd_addr 0..7,0..7; o_fifo_wr lags each issue by 1 cycle; 16 writes in total.
REQ-043 i_almostfull=1 for 3 cycles mid-frame -> o_rd_addr holds and o_fifo_wr=0 for those 3 cycles, delayed by 1; reading then resumes with no skipped address.
REQ-044 Second frame completes while the reader is at addr 3 -> rd_bank switches to 1 exactly when o_rd_addr wraps to 0; wr_bank becomes 0.
REQ-045 Two frames complete within one read frame -> one o_frame_drop pulse at the second sof; the reader then displays the later frame.
REQ-046 i_rst asserted during STREAM at addr 5 -> outputs 0 asynchronously; the next frame restarts from RD_IDLE with wr_bank=0.

Source files
------------

// File: rtl/frame_buf_ctrl.sv
// Double-buffered frame-buffer controller.
// A pixel writer fills one BRAM bank while a streaming reader drains the
// other into an output FIFO. Completed frames are handed to the reader only
// at a frame boundary, so the display never tears. A newer completed frame
// replaces an unread one, and that replacement is flagged on o_frame_drop.
module frame_buf_ctrl #(
    parameter int BRAM_DEPTH = 307200,
    parameter int AW         = 19
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic          i_sof,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_wr_bank,
    input  logic          i_req,
    input  logic          i_almostfull,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_bank,
    output logic          o_fifo_wr,
    output logic          o_frame_drop,
    output logic          o_rd_active
);

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_FILL = 2'd1;
    localparam logic [1:0] WR_DONE = 2'd2;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] STREAM  = 1'b1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

    logic [1:0]    wr_state;
    logic [AW-1:0] wr_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic          pending;
    logic [0:0]    rd_state;
    logic [AW-1:0] rd_addr;

    logic          sof;
    logic          accept;
    logic [AW-1:0] pix_addr;
    logic          complete;
    logic          issue;
    logic          rd_wrap;
    logic          swap;
    logic          drop;
    logic          pix_bank;

    // A sof pixel is always taken and restarts the frame at address 0;
    // other pixels are only taken while a frame is being filled.
    assign sof      = i_valid & i_sof;
    assign accept   = i_valid & (sof | (wr_state == WR_FILL));
    assign pix_addr = sof ? '0 : wr_cnt;
    assign complete = accept & (pix_addr == LAST_ADDR);

    // The reader pulls one pixel per cycle unless the FIFO is nearly full
    // or the display is not requesting data.
    assign issue   = (rd_state == STREAM) & i_req & ~i_almostfull;
    assign rd_wrap = issue & (rd_addr == LAST_ADDR);

    // Hand-over happens only when the reader is idle or at its frame boundary,
    // so the displayed bank never changes in the middle of a frame.
    assign swap = (pending | complete) & ((rd_state == RD_IDLE) | rd_wrap);

    // A new frame starting while a finished one is still waiting replaces it.
    assign drop = sof & pending & ~swap;

    // When a sof coincides with the hand-over, the new frame goes into the
    // bank the reader just released.
    assign pix_bank = (sof & swap) ? ~wr_bank : wr_bank;

    assign o_rd_addr   = rd_addr;
    assign o_rd_active = (rd_state == STREAM);
    // The read bank is meaningless until streaming starts, so it reads as 0
    // while idle even though the internal bank register starts at 1.
    assign o_rd_bank   = o_rd_active & rd_bank;

    // Registered port-A write controls, one cycle behind the pixel strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_bank <= 1'b0;
        end else begin
            o_wr_en <= accept;
            if (accept) begin
                o_wr_addr <= pix_addr;
                o_wr_bank <= pix_bank;
            end
        end
    end

    // Write FSM and next-pixel address counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_state <= WR_IDLE;
            wr_cnt   <= '0;
        end else if (sof) begin
            wr_state <= WR_FILL;
            wr_cnt   <= AW'(1);
        end else if (accept) begin
            if (complete) begin
                wr_state <= WR_DONE;
                wr_cnt   <= '0;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Bank ownership and the pending-frame flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            pending <= 1'b0;
        end else if (swap) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
            pending <= 1'b0;
        end else if (drop) begin
            pending <= 1'b0;
        end else if (complete) begin
            pending <= 1'b1;
        end
    end

    // Reader FSM, read address and the FIFO/drop strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_state     <= RD_IDLE;
            rd_addr      <= '0;
            o_fifo_wr    <= 1'b0;
            o_frame_drop <= 1'b0;
        end else begin
            if (swap) begin
                rd_state <= STREAM;
            end
            if (issue) begin
                rd_addr <= rd_wrap ? '0 : rd_addr + 1'b1;
            end
            o_fifo_wr    <= issue;
            o_frame_drop <= drop;
        end
    end

endmodule
